nbit_serial_subtractor: RTL and testbench



---
 rtl/nbit_serial_subtractor_pkg.sv | 27 ++
 rtl/nbit_serial_subtractor_if.sv | 47 ++++
 rtl/nbit_serial_subtractor_cla_sub_chunk.sv | 42 ++++
 rtl/nbit_serial_subtractor.sv | 169 ++++++++++++++++
 tb/tb_nbit_serial_subtractor.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nbit_serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// nbit_sub_pkg
// Shared types and helpers for the serial subtractor:
//   state_e   : controller states (IDLE, BUSY, DONE)
//   idx_width : width of the slice index counter, clog2(BIT_NUMBER/CHUNK),
//               never less than one bit
// -----------------------------------------------------------------------------
package nbit_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the slice index; a single-slice build still needs one bit.
  function automatic int idx_width(input int bit_number, input int chunk);
    int num_chunks;
    num_chunks = bit_number / chunk;
    if (num_chunks <= 1) begin
      return 1;
    end else begin
      return $clog2(num_chunks);
    end
  endfunction

endpackage : nbit_sub_pkg

// File: rtl/nbit_serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// nbit_serial_subtractor_if
// Operand / result handshake bundle of the serial subtractor.
//   in_valid, num_one, num_two : operand channel (producer -> subtractor)
//   in_ready                   : subtractor can accept operands
//   out_valid, D               : result channel {borrow, difference}
//   out_ready                  : consumer accepts the result
//   ovf                        : signed overflow flag, present only when
//                                NBIT_SUB_OVERFLOW_EN is defined
// Modports: master = operand producer / result consumer, slave = subtractor.
// -----------------------------------------------------------------------------
interface nbit_serial_subtractor_if #(
  parameter int BIT_NUMBER = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [BIT_NUMBER-1:0] num_one;
  logic [BIT_NUMBER-1:0] num_two;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIT_NUMBER:0]   D;
`ifdef NBIT_SUB_OVERFLOW_EN
  logic                  ovf;

  modport master (
    output in_valid, num_one, num_two, out_ready,
    input  in_ready, out_valid, D, ovf
  );

  modport slave (
    input  in_valid, num_one, num_two, out_ready,
    output in_ready, out_valid, D, ovf
  );
`else
  modport master (
    output in_valid, num_one, num_two, out_ready,
    input  in_ready, out_valid, D
  );

  modport slave (
    input  in_valid, num_one, num_two, out_ready,
    output in_ready, out_valid, D
  );
`endif

endinterface : nbit_serial_subtractor_if

// File: rtl/nbit_serial_subtractor_cla_sub_chunk.sv
// -----------------------------------------------------------------------------
// cla_sub_chunk
// Combinational CHUNK-bit slice subtractor: d = a - b - bin.
// Implemented as the adder a + ~b + ~bin using generate/propagate terms, so
// the borrow out is the inverted carry out.
//   a, b  : slice operands
//   bin   : borrow in from the lower slice
//   d     : slice difference
//   bout  : borrow out to the next slice
// -----------------------------------------------------------------------------
module cla_sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK-1:0] g_s;
  logic [CHUNK-1:0] p_s;
  logic [CHUNK:0]   c_s;

  // Generate/propagate of a + ~b; the inverted borrow is the carry in.
  always_comb begin
    g_s = a & ~b;
    p_s = a ^ ~b;
  end

  // Carry chain, difference bits and borrow out.
  always_comb begin
    c_s    = '0;
    c_s[0] = ~bin;
    for (int i = 0; i < CHUNK; i++) begin
      c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
    end
    d    = p_s ^ c_s[CHUNK-1:0];
    bout = ~c_s[CHUNK];
  end

endmodule : cla_sub_chunk

// File: rtl/nbit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// nbit_serial_subtractor
// Multi-cycle unsigned subtractor: D = {borrow, num_one - num_two mod
// 2^BIT_NUMBER}, computed one CHUNK-bit slice per clock with the borrow
// carried between slices. Latency from input handshake to out_valid is
// BIT_NUMBER/CHUNK cycles. BIT_NUMBER must be a multiple of CHUNK.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : nbit_serial_subtractor_if.slave (in_valid/in_ready/num_one/
//            num_two, out_valid/out_ready/D, optional ovf)
//
// Build option: NBIT_SUB_OVERFLOW_EN adds bus.ovf, the signed two's-complement
// overflow of num_one - num_two, valid with out_valid and held with D.
//
// in_ready and out_valid are registered. in_ready stays low during reset and
// rises on the first clock edge after release.
// -----------------------------------------------------------------------------
module nbit_serial_subtractor
  import nbit_sub_pkg::*;
#(
  parameter int BIT_NUMBER = 8,
  parameter int CHUNK      = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  nbit_serial_subtractor_if.slave bus
);

  localparam int                NUM_CHUNKS = BIT_NUMBER / CHUNK;
  localparam int                IDX_W      = idx_width(BIT_NUMBER, CHUNK);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_CHUNKS - 1);
  localparam int                MSB        = BIT_NUMBER - 1;

  state_e                state_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  borrow_r;
  logic [BIT_NUMBER-1:0] a_r;
  logic [BIT_NUMBER-1:0] b_r;
  logic [BIT_NUMBER-1:0] diff_r;
  logic [BIT_NUMBER:0]   d_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
`ifdef NBIT_SUB_OVERFLOW_EN
  logic                  ovf_r;
`endif

  logic [CHUNK-1:0]      a_slice_s;
  logic [CHUNK-1:0]      b_slice_s;
  logic [CHUNK-1:0]      d_slice_s;
  logic                  bout_s;
  logic [BIT_NUMBER-1:0] diff_next_s;

  // Select the operand slice addressed by the index counter.
  always_comb begin
    a_slice_s = '0;
    b_slice_s = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx_r == IDX_W'(k)) begin
        a_slice_s = a_r[k*CHUNK +: CHUNK];
        b_slice_s = b_r[k*CHUNK +: CHUNK];
      end else begin
        a_slice_s = a_slice_s;
        b_slice_s = b_slice_s;
      end
    end
  end

  cla_sub_chunk #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a    (a_slice_s),
    .b    (b_slice_s),
    .bin  (borrow_r),
    .d    (d_slice_s),
    .bout (bout_s)
  );

  // Merge the fresh slice result into the running difference.
  always_comb begin
    diff_next_s = diff_r;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx_r == IDX_W'(k)) begin
        diff_next_s[k*CHUNK +: CHUNK] = d_slice_s;
      end else begin
        diff_next_s[k*CHUNK +: CHUNK] = diff_r[k*CHUNK +: CHUNK];
      end
    end
  end

  // Controller FSM, slice counter, operand/result registers and handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      borrow_r    <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      diff_r      <= '0;
      d_r         <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef NBIT_SUB_OVERFLOW_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          // in_ready_r gates acceptance so operands are only taken on an
          // edge where in_ready was visibly high.
          if (in_ready_r && bus.in_valid) begin
            a_r        <= bus.num_one;
            b_r        <= bus.num_two;
            borrow_r   <= 1'b0;
            idx_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= BUSY;
          end else begin
            in_ready_r <= 1'b1;
          end
        end

        BUSY: begin
          diff_r   <= diff_next_s;
          borrow_r <= bout_s;
          if (idx_r == LAST_IDX) begin
            d_r         <= {bout_s, diff_next_s};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
`ifdef NBIT_SUB_OVERFLOW_EN
            // Signed overflow: operands differ in sign and the result sign
            // differs from the minuend sign.
            ovf_r <= (a_r[MSB] != b_r[MSB]) && (diff_next_s[MSB] != a_r[MSB]);
`endif
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end

        DONE: begin
          // D (and ovf) stay untouched here so they remain valid after the
          // handshake until the next result overwrites them.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end

        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.D         = d_r;
`ifdef NBIT_SUB_OVERFLOW_EN
  assign bus.ovf       = ovf_r;
`endif

endmodule : nbit_serial_subtractor

// File: tb/tb_nbit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_nbit_serial_subtractor
// Directed bench for nbit_serial_subtractor. Three instances (CHUNK = 4, 1, 8,
// all 8-bit) share the same stimulus; the CHUNK=4 instance carries the main
// scenarios, the other two cover the multi-slice and single-slice extremes.
// Honours NBIT_SUB_OVERFLOW_EN for the ovf checks.
// -----------------------------------------------------------------------------
module tb_nbit_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] num_one = 8'h00;
  logic [7:0] num_two = 8'h00;

  int checks = 0;
  int failures = 0;

  nbit_serial_subtractor_if #(.BIT_NUMBER(8)) bus4 ();
  nbit_serial_subtractor_if #(.BIT_NUMBER(8)) bus1 ();
  nbit_serial_subtractor_if #(.BIT_NUMBER(8)) bus8 ();

  assign bus4.in_valid = in_valid;
  assign bus4.num_one = num_one;
  assign bus4.num_two = num_two;
  assign bus4.out_ready = out_ready;
  assign bus1.in_valid = in_valid;
  assign bus1.num_one = num_one;
  assign bus1.num_two = num_two;
  assign bus1.out_ready = out_ready;
  assign bus8.in_valid = in_valid;
  assign bus8.num_one = num_one;
  assign bus8.num_two = num_two;
  assign bus8.out_ready = out_ready;

  nbit_serial_subtractor #(.BIT_NUMBER(8), .CHUNK(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  nbit_serial_subtractor #(.BIT_NUMBER(8), .CHUNK(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  nbit_serial_subtractor #(.BIT_NUMBER(8), .CHUNK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the CHUNK=4 instance to be ready.
  task automatic wait_ready4();
    int n = 0;
    while (bus4.in_ready !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    checks++;
    if (bus4.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready4: in_ready=%b required 1 within 16 cycles", bus4.in_ready);
    end
  endtask

  // One full operation on the CHUNK=4 instance with latency and result checks.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] exp_d, input logic exp_ovf);
    wait_ready4();
    in_valid = 1'b1;
    num_one = a;
    num_two = b;
    tick();
    in_valid = 1'b0;
    checks++;
    if (bus4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_early_n0: out_valid=%b required 0", name, bus4.out_valid);
    end
    tick();
    checks++;
    if (bus4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_early_n1: out_valid=%b required 0", name, bus4.out_valid);
    end
    tick();
    checks++;
    if (bus4.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid_n2: out_valid=%b required 1", name, bus4.out_valid);
    end
    checks++;
    if (bus4.D !== exp_d) begin
      failures++;
      $display("FAIL %s_D: D=%h required %h", name, bus4.D, exp_d);
    end
    checks++;
    if (bus4.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_in_ready_done: in_ready=%b required 0", name, bus4.in_ready);
    end
`ifdef NBIT_SUB_OVERFLOW_EN
    checks++;
    if (bus4.ovf !== exp_ovf) begin
      failures++;
      $display("FAIL %s_ovf: ovf=%b required %b", name, bus4.ovf, exp_ovf);
    end
`else
    if (exp_ovf === 1'bx) $display("note: unexpected unknown ovf expectation");
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1", name, bus4.out_valid, bus4.in_ready);
    end
    checks++;
    if (bus4.D !== exp_d) begin
      failures++;
      $display("FAIL %s_D_hold: D=%h required %h", name, bus4.D, exp_d);
    end
  endtask

  // One operation on all instances; measures CHUNK=1 and CHUNK=8 latency.
  task automatic variant_op(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [8:0] exp_d);
    int n = 0;
    int first1 = 0;
    int first8 = 0;
    while ((bus1.in_ready !== 1'b1 || bus8.in_ready !== 1'b1) && n < 16) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    num_one = a;
    num_two = b;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus1.out_valid === 1'b1 && first1 == 0) first1 = k;
      if (bus8.out_valid === 1'b1 && first8 == 0) first8 = k;
    end
    checks++;
    if (first8 != 1) begin
      failures++;
      $display("FAIL %s_lat_chunk8: latency=%0d required 1", name, first8);
    end
    checks++;
    if (first1 != 8) begin
      failures++;
      $display("FAIL %s_lat_chunk1: latency=%0d required 8", name, first1);
    end
    checks++;
    if (bus8.D !== exp_d) begin
      failures++;
      $display("FAIL %s_D_chunk8: D=%h required %h", name, bus8.D, exp_d);
    end
    checks++;
    if (bus1.D !== exp_d) begin
      failures++;
      $display("FAIL %s_D_chunk1: D=%h required %h", name, bus1.D, exp_d);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus4.in_ready !== 1'b0 || bus4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b required 0 0", bus4.in_ready, bus4.out_valid);
    end
    checks++;
    if (bus4.D !== 9'h000) begin
      failures++;
      $display("FAIL reset_D: D=%h required 000", bus4.D);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", bus4.in_ready, bus4.out_valid);
    end
  endtask

  task automatic test_no_borrow();
    run_op("no_borrow", 8'h35, 8'h12, 9'h023, 1'b0);
  endtask

  task automatic test_borrow();
    run_op("borrow", 8'h12, 8'h35, 9'h1DD, 1'b0);
  endtask

  task automatic test_overflow();
    run_op("ovf_80_01", 8'h80, 8'h01, 9'h07F, 1'b1);
    run_op("zero", 8'h00, 8'h00, 9'h000, 1'b0);
    run_op("ovf_7f_ff", 8'h7F, 8'hFF, 9'h180, 1'b1);
  endtask

  task automatic test_backpressure();
    wait_ready4();
    in_valid = 1'b1;
    num_one = 8'h35;
    num_two = 8'h12;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      num_one = 8'hAA;
      num_two = 8'h55;
      tick();
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0 || bus4.D !== 9'h023) begin
        failures++;
        $display("FAIL backpressure_stall%0d: out_valid=%b in_ready=%b D=%h required 1 0 023",
                 k, bus4.out_valid, bus4.in_ready, bus4.D);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.D !== 9'h023) begin
      failures++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b D=%h required 0 1 023",
               bus4.out_valid, bus4.in_ready, bus4.D);
    end
  endtask

  task automatic test_reset_mid_busy();
    wait_ready4();
    in_valid = 1'b1;
    num_one = 8'hFF;
    num_two = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b0 || bus4.D !== 9'h000) begin
      failures++;
      $display("FAIL mid_busy_reset: out_valid=%b in_ready=%b D=%h required 0 0 000",
               bus4.out_valid, bus4.in_ready, bus4.D);
    end
    #2;
    rst_n = 1'b1;
    run_op("after_reset", 8'hFF, 8'h01, 9'h0FE, 1'b0);
  endtask

  task automatic test_chunk_variants();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    variant_op("var_ff_01", 8'hFF, 8'h01, 9'h0FE);
    variant_op("var_12_35", 8'h12, 8'h35, 9'h1DD);
    // Reset the CHUNK=1 instance part-way through its eight slices.
    in_valid = 1'b1;
    num_one = 8'hFF;
    num_two = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus1.out_valid !== 1'b0 || bus1.D !== 9'h000 || bus8.D !== 9'h000) begin
      failures++;
      $display("FAIL var_mid_reset: chunk1 out_valid=%b D=%h chunk8 D=%h required 0 000 000",
               bus1.out_valid, bus1.D, bus8.D);
    end
    #2;
    rst_n = 1'b1;
    variant_op("var_after_reset", 8'hFF, 8'h01, 9'h0FE);
  endtask

  initial begin
    test_reset();
    test_no_borrow();
    test_borrow();
    test_overflow();
    test_backpressure();
    test_reset_mid_busy();
    test_chunk_variants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nbit_serial_subtractor
